// File: rtl/Pu_interrupt.sv
// Shared definitions for the external interrupt controller: register map,
// controller FSM encoding and CLAIM register layout.
package Pu_interrupt;

    localparam logic [1:0] EXT_INT_ENABLE  = 2'd0;
    localparam logic [1:0] EXT_INT_EDGE    = 2'd1;
    localparam logic [1:0] EXT_INT_PENDING = 2'd2;
    localparam logic [1:0] EXT_INT_CLAIM   = 2'd3;

    typedef enum logic [1:0] {
        EXT_IDLE = 2'd0,
        EXT_REQ  = 2'd1,
        EXT_GAP  = 2'd2
    } Ext_int_state;

    localparam int CLAIM_VALID_BIT = 31;

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: multi-flop synchroniser followed by a previous-value
// flop, giving the synchronised level and a one-cycle rising-edge strobe.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: synchronises device lines, keeps a masked
// pending set and presents the lowest-index eligible source to the scheduler.
module ext_int_ctrl
    import Pu_interrupt::*;
#(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               base_ext_input,
    input  logic               base_ext_input_ack,
    output logic [ID_W-1:0]    int_id,
    output logic               pend_any
);

    logic [NUM_SRC-1:0] sync_level, sync_rise;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
            .clk       (clk),
            .reset     (reset),
            .irq_async (irq_in[g]),
            .level     (sync_level[g]),
            .rise      (sync_rise[g])
        );
    end

    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               claim_valid_q, claim_valid_d;
    logic [ID_W-1:0]    claim_id_q, claim_id_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic               pend_any_q, pend_any_d;
    Ext_int_state       state_q, state_d;

    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    lowest_id;
    logic               ack_fire;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;
    assign eligible     = pending_q & enable_q;
    assign ack_fire     = (state_q == EXT_REQ) && base_ext_input_ack;

    always_comb begin
        lowest_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) lowest_id = ID_W'(i);
        end
    end

    always_comb begin
        enable_d      = enable_q;
        edge_d        = edge_q;
        claim_valid_d = claim_valid_q;
        claim_id_d    = claim_id_q;
        int_id_d      = int_id_q;
        state_d       = state_q;
        w1c           = '0;
        pend_any_d    = |eligible;

        if (cfg_we) begin
            case (cfg_addr)
                EXT_INT_ENABLE:  enable_d = cfg_wdata[NUM_SRC-1:0];
                EXT_INT_EDGE:    edge_d   = cfg_wdata[NUM_SRC-1:0];
                EXT_INT_PENDING: w1c      = cfg_wdata[NUM_SRC-1:0];
                default:         claim_valid_d = 1'b0;
            endcase
        end

        // Edge sources: a new rising edge beats any clear landing in the same cycle.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_q[i]) begin
                pending_d[i] = sync_rise[i] |
                               (pending_q[i] & ~w1c[i] &
                                ~(ack_fire && (int_id_q == ID_W'(i))));
            end else begin
                pending_d[i] = sync_level[i];
            end
        end

        case (state_q)
            EXT_IDLE: begin
                if (|eligible) begin
                    int_id_d = lowest_id;
                    state_d  = EXT_REQ;
                end
            end
            EXT_REQ: begin
                if (base_ext_input_ack) begin
                    claim_valid_d = 1'b1;
                    claim_id_d    = int_id_q;
                    state_d       = EXT_GAP;
                end else if (!eligible[int_id_q]) begin
                    state_d = EXT_IDLE;
                end
            end
            default: state_d = EXT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q      <= '0;
            edge_q        <= '0;
            pending_q     <= '0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
            int_id_q      <= '0;
            pend_any_q    <= 1'b0;
            state_q       <= EXT_IDLE;
        end else begin
            enable_q      <= enable_d;
            edge_q        <= edge_d;
            pending_q     <= pending_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            int_id_q      <= int_id_d;
            pend_any_q    <= pend_any_d;
            state_q       <= state_d;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            EXT_INT_ENABLE:  cfg_rdata[NUM_SRC-1:0] = enable_q;
            EXT_INT_EDGE:    cfg_rdata[NUM_SRC-1:0] = edge_q;
            EXT_INT_PENDING: cfg_rdata[NUM_SRC-1:0] = pending_q;
            default: begin
                cfg_rdata[CLAIM_VALID_BIT] = claim_valid_q;
                cfg_rdata[ID_W-1:0]        = claim_id_q;
            end
        endcase
    end

    assign base_ext_input = (state_q == EXT_REQ);
    assign int_id         = int_id_q;
    assign pend_any       = pend_any_q;

endmodule
